// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer: note period table,
// beat constant, channel FSM states and the FIFO command word.
package note_pkg;

   localparam int unsigned SEC_PER_MIN = 60;

   // Period word for each note index 0..15
   localparam logic [17:0] NOTE_PERIOD [16] = '{
      18'd191117, 18'd170265, 18'd160710, 18'd151690,
      18'd143176, 18'd127551, 18'd120395, 18'd113636,
      18'd107259, 18'd101239, 18'd95555,  18'd90194,
      18'd85132,  18'd80352,  18'd75843,  18'd71586
   };

   typedef enum logic {StIdle, StPlay} ch_state_e;

   typedef struct packed {
      logic [3:0] note;
      logic [2:0] beats;
   } cmd_t;

endpackage

// File: rtl/note_channel.sv
// One sequencer voice: command FIFO, IDLE/PLAY FSM, beat countdown and
// period register. flush and rst both return the voice to silence.
module note_channel
   import note_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PERIOD_W   = 21
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                push,
   input  logic [3:0]          push_note,
   input  logic [2:0]          push_beats,
   input  logic                beat_tick,
   output logic                full,
   output logic                busy,
   output logic                done,
   output logic [PERIOD_W-1:0] period
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   cmd_t                mem [FIFO_DEPTH];
   cmd_t                head;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]      count_q, count_d;
   ch_state_e           state_q, state_d;
   logic [2:0]          rem_q, rem_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                done_q, done_d;
   logic                pop, push_ok, empty;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign push_ok = push & ~full & ~flush;
   assign head    = mem[rd_ptr_q];

   assign busy   = (state_q == StPlay) | ~empty;
   assign done   = done_q;
   assign period = period_q;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      period_d = period_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop = 1'b1;
               // A zero-beat command is consumed without sounding
               if (head.beats != 3'd0) begin
                  state_d  = StPlay;
                  rem_d    = head.beats;
                  period_d = PERIOD_W'(NOTE_PERIOD[head.note]);
               end
            end
         end
         StPlay: begin
            if (beat_tick) begin
               if (rem_q > 3'd1) begin
                  rem_d = rem_q - 3'd1;
               end else begin
                  done_d = 1'b1;
                  if (!empty && head.beats != 3'd0) begin
                     pop      = 1'b1;
                     rem_d    = head.beats;
                     period_d = PERIOD_W'(NOTE_PERIOD[head.note]);
                  end else begin
                     pop      = ~empty;
                     state_d  = StIdle;
                     period_d = '0;
                  end
               end
            end
         end
         default: begin
            state_d  = StIdle;
            period_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         period_q <= period_d;
         done_q   <= done_d;
         count_q  <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= {push_note, push_beats};
   end

endmodule

// File: rtl/note_sequencer.sv
// Polyphonic note sequencer: shared tempo accumulator producing beat ticks,
// and one note_channel per voice fed from a single PLY command port.
module note_sequencer
   import note_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned PERIOD_W   = 21
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ply_valid,
   output logic                         ply_ready,
   input  logic [$clog2(NUM_CH)-1:0]    ply_ch,
   input  logic [3:0]                   ply_note,
   input  logic [2:0]                   ply_beats,
   input  logic [10:0]                  bpm,
   input  logic                         flush,
   output logic [NUM_CH*PERIOD_W-1:0]   ch_period,
   output logic [NUM_CH-1:0]            ch_busy,
   output logic [NUM_CH-1:0]            ch_done
);

   localparam int unsigned CH_W       = $clog2(NUM_CH);
   localparam logic [32:0] BEAT_LIMIT = 33'(CLK_HZ) * 33'(SEC_PER_MIN);

   logic [NUM_CH-1:0] ch_full;
   logic [NUM_CH-1:0] ch_push;
   logic [31:0]       acc_q, acc_d;
   logic [32:0]       acc_sum;
   logic              beat_tick;

   assign ply_ready = ~flush & ~ch_full[ply_ch];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_push[c] = ply_valid & ply_ready & (ply_ch == CH_W'(c));
      end
   end

   // Restart the beat phase whenever the whole sequencer is silent
   always_comb begin
      acc_sum   = {1'b0, acc_q} + {22'd0, bpm};
      acc_d     = acc_sum[31:0];
      beat_tick = 1'b0;
      if (flush || ch_busy == '0) begin
         acc_d = '0;
      end else if (acc_sum >= BEAT_LIMIT) begin
         acc_d     = 32'(acc_sum - BEAT_LIMIT);
         beat_tick = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      note_channel #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .PERIOD_W   (PERIOD_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .push       (ch_push[c]),
         .push_note  (ply_note),
         .push_beats (ply_beats),
         .beat_tick  (beat_tick),
         .full       (ch_full[c]),
         .busy       (ch_busy[c]),
         .done       (ch_done[c]),
         .period     (ch_period[c*PERIOD_W +: PERIOD_W])
      );
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CLK_HZ=100 and bpm=60, so one beat
// lasts 100 clocks once the accumulator is running.
module tb_note_sequencer;

   localparam int unsigned PW = 21;

   logic          clk = 1'b0;
   logic          rst, ply_valid, ply_ready, flush;
   logic [1:0]    ply_ch;
   logic [3:0]    ply_note;
   logic [2:0]    ply_beats;
   logic [10:0]   bpm;
   logic [4*PW-1:0] ch_period;
   logic [3:0]    ch_busy, ch_done;

   int n_cmp = 0;
   int n_bad = 0;
   int hi, hi2, other, dn, dn_sil, gap, seen2;

   always #5 clk = ~clk;

   note_sequencer #(
      .NUM_CH     (4),
      .FIFO_DEPTH (8),
      .CLK_HZ     (100),
      .PERIOD_W   (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ply_valid (ply_valid),
      .ply_ready (ply_ready),
      .ply_ch    (ply_ch),
      .ply_note  (ply_note),
      .ply_beats (ply_beats),
      .bpm       (bpm),
      .flush     (flush),
      .ch_period (ch_period),
      .ch_busy   (ch_busy),
      .ch_done   (ch_done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] per(input int c);
      return ch_period[c*PW +: PW];
   endfunction

   task automatic push(input int ch, input int note, input int beats);
      ply_ch    = 2'(ch);
      ply_note  = 4'(note);
      ply_beats = 3'(beats);
      ply_valid = 1'b1;
      #1;
      check("push_ready", ply_ready, 1);
      step();
      ply_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ply_valid = 1'b0; flush = 1'b0; bpm = 11'd60;
      ply_ch = '0; ply_note = '0; ply_beats = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_period", ch_period == '0, 1);
      check("rst_busy", ch_busy, 0);
      check("rst_done", ch_done, 0);
      check("rst_ready", ply_ready, 1);

      // Single two-beat note on ch0
      push(0, 7, 2);
      hi = 0; other = 0; dn = 0; dn_sil = 0;
      for (int i = 0; i < 260; i++) begin
         step();
         if (per(0) == 21'd113636) hi++;
         else if (per(0) != '0) other++;
         if (ch_done[0]) begin
            dn++;
            if (per(0) == '0) dn_sil++;
         end
      end
      check("a_len", hi >= 199 && hi <= 200, 1);
      check("a_other", other, 0);
      check("a_done_cnt", dn, 1);
      check("a_done_silent", dn_sil, 1);
      check("a_period_end", per(0), 0);
      check("a_busy_end", ch_busy, 0);

      // Back-to-back notes on ch1 must be gapless
      push(1, 0, 1);
      push(1, 15, 1);
      check("b_first_start", per(1), 191117);
      hi = (per(1) == 21'd191117) ? 1 : 0;
      hi2 = 0; gap = 0; seen2 = 0; dn = 0; other = 0;
      for (int i = 0; i < 260; i++) begin
         step();
         if (per(1) == 21'd191117) hi++;
         else if (per(1) == 21'd71586) begin hi2++; seen2 = 1; end
         else if (per(1) == '0) begin if (seen2 == 0) gap++; end
         else other++;
         if (ch_done[1]) dn++;
      end
      check("b_first_len", hi >= 99 && hi <= 100, 1);
      check("b_second_len", hi2, 100);
      check("b_gap", gap, 0);
      check("b_other", other, 0);
      check("b_done_cnt", dn, 2);
      check("b_period_end", per(1), 0);

      // Fill ch2 while it plays a long note; ch3 must stay available
      push(2, 3, 7);
      for (int i = 0; i < 8; i++) push(2, i, 1);
      ply_ch = 2'd2; ply_valid = 1'b1;
      #1;
      check("c_ready_ch2_full", ply_ready, 0);
      check("c_busy2", ch_busy[2], 1);
      ply_ch = 2'd0;
      #1;
      check("c_ready_ch0", ply_ready, 1);
      ply_ch = 2'd3; ply_note = 4'd5; ply_beats = 3'd1;
      #1;
      check("c_ready_ch3", ply_ready, 1);
      step();
      ply_valid = 1'b0;
      step();
      check("c_period3", per(3), 127551);
      check("c_period2", per(2), 151690);

      // Flush mid-note with a command presented in the same cycle
      flush = 1'b1; ply_valid = 1'b1; ply_ch = 2'd0; ply_note = 4'd1; ply_beats = 3'd3;
      #1;
      check("d_ready_flush", ply_ready, 0);
      step();
      flush = 1'b0; ply_valid = 1'b0;
      check("d_period", ch_period == '0, 1);
      check("d_busy", ch_busy, 0);
      check("d_done", ch_done, 0);
      step();
      step();
      check("d_dropped", ch_period == '0, 1);
      check("d_busy_later", ch_busy, 0);
      ply_ch = 2'd2;
      #1;
      check("d_ready_ch2", ply_ready, 1);

      // Zero-beat command is silent, following note plays normally
      push(0, 9, 0);
      push(0, 4, 1);
      hi = 0; other = 0; dn = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (per(0) == 21'd143176) hi++;
         else if (per(0) != '0) other++;
         if (ch_done[0]) dn++;
      end
      check("e_len", hi >= 98 && hi <= 100, 1);
      check("e_other", other, 0);
      check("e_done_cnt", dn, 1);

      // Tempo stop holds the note, restart resumes the countdown
      push(1, 2, 2);
      repeat (50) step();
      bpm = 11'd0;
      dn = 0; other = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (ch_done[1]) dn++;
         if (per(1) != 21'd160710) other++;
      end
      check("f_hold_done", dn, 0);
      check("f_hold_period", other, 0);
      check("f_hold_busy", ch_busy[1], 1);
      bpm = 11'd60;
      dn = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (ch_done[1]) dn++;
      end
      check("f_resume_done", dn, 1);
      check("f_resume_period", per(1), 0);
      check("f_end_busy", ch_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
